// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants.
// Used by both the transmitter and the receiver so their frame formats match.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DEF_OS      = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity, stop.
// Paced by a 16x oversample tick; the line driver is registered so tx is glitch-free.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (sense set by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = DEF_DBIT,
  parameter int OS         = DEF_OS,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int S_W   = cnt_w(S_MAX);
  localparam int N_W   = cnt_w(DBIT);

  localparam logic [S_W-1:0] OS_LAST = S_W'(OS - 1);
  localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(DBIT - 1);

  state_t          state_reg, state_next;
  logic [S_W-1:0]  s_reg, s_next;
  logic [N_W-1:0]  n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done;
  logic            p_bit;

`ifdef UART_TX_PARITY_EN
  logic p_reg, p_next;

  assign p_bit = p_reg;
`else
  // PARITY is unreachable in this build; the level is never driven onto the line.
  assign p_bit = (PARITY_ODD != 0);
`endif

  // State, counters, shift register and line driver; everything returns to idle on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      p_reg     <= p_next;
`endif
    end
  end

  // Next-state, counter updates and the line level the next state will drive.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done       = 1'b0;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    p_next     = p_reg;
`endif

    case (state_reg)
      IDLE: begin
        // A tick coinciding with accept is deliberately not counted.
        if (tx_start) begin
          b_next     = din;
          s_next     = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          p_next     = (^din) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + N_W'(1);
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered, so it changes on the same edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_bit;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = done & ~reset;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a tick-count frame model checked every cycle,
// plus directed frames with hand-computed line levels and done timing.
module tb_uart_tx;

  localparam int DBIT    = 8;
  localparam int OS      = 16;
  localparam int SB_TICK = 16;
  localparam int P_ODD   = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR      = 1;
  localparam int DONE_LIT = 176;
`else
  localparam int PAR      = 0;
  localparam int DONE_LIT = 160;
`endif
  localparam int FRAME = (DBIT + 1 + PAR) * OS + SB_TICK;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_tick = 1'b0;
  logic            tx_start = 1'b0;
  logic [DBIT-1:0] din = '0;
  logic            tx, tx_busy, tx_done_tick;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  uart_tx #(
    .DBIT(DBIT), .OS(OS), .SB_TICK(SB_TICK), .PARITY_ODD(P_ODD)
  ) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line level after k ticks of a frame carrying d.
  function automatic logic line_bit(input logic [DBIT-1:0] d, input int k);
    int idx;
    idx = k / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return d[idx-1];
    if (PAR == 1 && idx == DBIT + 1) return (^d) ^ (P_ODD != 0);
    return 1'b1;
  endfunction

  // Reference model: a frame is "busy" from accept until FRAME ticks have been consumed.
  bit              m_busy = 1'b0;
  int              m_k = 0;
  logic [DBIT-1:0] m_data = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (tx_start) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_data <= din;
      end
    end else if (s_tick) begin
      if (m_k == FRAME - 1) m_busy <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_tx, e_done;
    if (chk_en) begin
      e_tx   = m_busy ? line_bit(m_data, m_k) : 1'b1;
      e_done = m_busy && s_tick && !reset && (m_k == FRAME - 1);
      check("model_tx", {31'b0, tx}, {31'b0, e_tx});
      check("model_busy", {31'b0, tx_busy}, {31'b0, m_busy});
      check("model_done", {31'b0, tx_done_tick}, {31'b0, e_done});
    end
    if (tx_done_tick) done_cnt++;
  end

  // One clock of stimulus; returns at the following negedge for sampling.
  task automatic cyc(input logic st, input logic tk, input logic [DBIT-1:0] d, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    tx_start = st;
    s_tick   = tk;
    din      = d;
    reset    = rs;
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] exp_a5;
    int first_done, second_done, d0;

    exp_a5 = 9'b101001010;  // start then 0xA5 LSB-first, index 0 first

    // Reset state
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    chk_en = 1'b1;
    cyc(0, 1, '0, 1);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_done", {31'b0, tx_done_tick}, 32'd0);
    cyc(0, 1, '0);

    // Basic 0xA5 frame with an ignored request (0x3C) at cycle 50
    d0 = done_cnt;
    first_done = -1;
    cyc(1, 1, 8'hA5);
    for (int c = 1; c <= 175; c++) begin
      cyc(c == 50, 1'b1, (c == 50) ? 8'h3C : DBIT'($urandom));
      if (tx_done_tick && first_done < 0) first_done = c;
      if (c % 16 == 8 && c / 16 <= 8)
        check($sformatf("a5_bit%0d", c / 16), {31'b0, tx}, {31'b0, exp_a5[c/16]});
      if (c == 100) check("a5_busy_mid", {31'b0, tx_busy}, 32'd1);
    end
    check("a5_done_clk", first_done, DONE_LIT);
    check("a5_done_count", done_cnt - d0, 32'd1);
    check("a5_idle_tx", {31'b0, tx}, 32'd1);
    check("a5_idle_busy", {31'b0, tx_busy}, 32'd0);

    // Back-to-back: tx_start held, 0x00 then 0xFF
    d0 = done_cnt;
    first_done = -1;
    second_done = -1;
    cyc(1, 1, 8'h00);
    for (int c = 1; c <= 2 * DONE_LIT + 20; c++) begin
      cyc(c <= DONE_LIT + 10, 1'b1, (c > DONE_LIT) ? 8'hFF : 8'h00);
      if (tx_done_tick) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (c == 3 * 16 + 8) check("b2b_f0_bit2", {31'b0, tx}, 32'd0);
      if (c == DONE_LIT + 1) begin
        check("b2b_gap_busy", {31'b0, tx_busy}, 32'd0);
        check("b2b_gap_tx", {31'b0, tx}, 32'd1);
      end
      if (c == DONE_LIT + 2) check("b2b_start2", {31'b0, tx}, 32'd0);
      if (c == DONE_LIT + 1 + 3 * 16 + 8) check("b2b_ff_bit2", {31'b0, tx}, 32'd1);
    end
    check("b2b_done1", first_done, DONE_LIT);
    check("b2b_done2", second_done, 2 * DONE_LIT + 1);
    check("b2b_done_count", done_cnt - d0, 32'd2);

    // Slow tick: every 4th clk, 0x81
    first_done = -1;
    cyc(1, 0, 8'h81);
    for (int c = 1; c <= 4 * DONE_LIT + 20; c++) begin
      cyc(0, (c % 4) == 0, DBIT'($urandom));
      if (tx_done_tick && first_done < 0) first_done = c;
      if (c == 32) check("slow_start", {31'b0, tx}, 32'd0);
      if (c == 64 + 32) check("slow_bit0", {31'b0, tx}, 32'd1);
      if (c == 128 + 32) check("slow_bit1", {31'b0, tx}, 32'd0);
    end
    check("slow_done_clk", first_done, 4 * DONE_LIT);

    // Reset during data bit 3, then a clean 0x5A frame
    d0 = done_cnt;
    cyc(1, 1, 8'hC3);
    for (int c = 1; c <= 71; c++) cyc(0, 1'b1, DBIT'($urandom));
    cyc(0, 1, 8'h00, 1);
    cyc(0, 1, 8'h00);
    check("rstmid_tx", {31'b0, tx}, 32'd1);
    check("rstmid_busy", {31'b0, tx_busy}, 32'd0);
    check("rstmid_no_done", done_cnt - d0, 32'd0);
    first_done = -1;
    cyc(1, 1, 8'h5A);
    for (int c = 1; c <= DONE_LIT + 5; c++) begin
      cyc(0, 1'b1, DBIT'($urandom));
      if (tx_done_tick && first_done < 0) first_done = c;
      if (c == 16 + 8) check("5a_bit0", {31'b0, tx}, 32'd0);
      if (c == 32 + 8) check("5a_bit1", {31'b0, tx}, 32'd1);
    end
    check("5a_done_clk", first_done, DONE_LIT);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones -> parity 1; 0x03 has two -> parity 0
    cyc(1, 1, 8'h07);
    for (int c = 1; c <= DONE_LIT + 5; c++) begin
      cyc(0, 1'b1, DBIT'($urandom));
      if (c == 9 * 16 + 8) check("par_07", {31'b0, tx}, 32'd1);
    end
    cyc(1, 1, 8'h03);
    for (int c = 1; c <= DONE_LIT + 5; c++) begin
      cyc(0, 1'b1, DBIT'($urandom));
      if (c == 9 * 16 + 8) check("par_03", {31'b0, tx}, 32'd0);
    end
`endif

    // Randomized traffic: sparse ticks, random requests, rare resets
    for (int i = 0; i < 5000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 99) < 40, DBIT'($urandom),
          $urandom_range(0, 1999) == 0);
    end

    cyc(0, 0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: the serialising counterpart of the rx receive stage.
- Shares the same baud_rate_generator s_tick (16x oversample) and uses the same frame format: start bit, DBIT data bits LSB-first, stop.
- Downstream of the TX-side FIFO. The system drives tx_start = ~empty & ~tx_busy and pops the FIFO on tx_done_tick.
- Output tx drives the serial line, or the rx input in loopback.

Parameters:
- DBIT, 8, number of data bits per frame.
- OS, 16, s_tick count per start/data/parity bit.
- SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_tick  in  1  oversample tick from baud_rate_generator, one clk wide.
- tx_start  in  1  request to send din; honoured only in IDLE.
- din  in  DBIT  byte to transmit; sampled in the accept cycle only.
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  high in every state except IDLE.
- tx_done_tick  out  1  one-clk pulse at the end of the stop period.

Behaviour:
- Clocking and reset:
  - One clock domain, clk. Reset is synchronous and active-high on reset.
  - Reset values: state = IDLE, tx = 1, tx_busy = 0, tx_done_tick = 0, tick counter = 0, bit counter = 0, shift register = 0.
- Registers:
  - s_reg: tick counter, width clog2(max(OS, SB_TICK)).
  - n_reg: data-bit counter, width clog2(DBIT).
  - b_reg: DBIT shift register.
  - tx_reg: registered line driver, so tx is glitch-free.
- IDLE:
  - tx = 1.
  - On tx_start: b_reg <= din, s_reg <= 0, go to START.
  - tx goes low on the next clk edge.
  - An s_tick in the accept cycle is not counted.
- START:
  - tx = 0.
  - On s_tick: if s_reg == OS-1 then s_reg <= 0, n_reg <= 0, go to DATA; else s_reg++.
- DATA:
  - tx = b_reg[0].
  - On s_tick with s_reg == OS-1: s_reg <= 0, b_reg shifts right by one.
  - Then, if n_reg == DBIT-1, go to STOP (or PARITY); else n_reg++.
  - Other s_tick: s_reg++.
- STOP:
  - tx = 1.
  - On s_tick with s_reg == SB_TICK-1: tx_done_tick = 1 for that cycle only, go to IDLE.
  - Other s_tick: s_reg++.
- Timing:
  - Without parity, a frame lasts (DBIT+1)*OS + SB_TICK ticks after accept; with the defaults, 160 ticks.
  - tx_done_tick asserts on the clk where the final tick is consumed; tx_busy falls on the next edge.
- Boundary conditions:
  - tx_start while busy, including the tx_done_tick cycle: ignored, with no queuing.
  - A new request is accepted the cycle after tx_done_tick, so a held tx_start gives back-to-back frames with no idle gap beyond one clk.
  - din changing after accept has no effect.
  - s_tick absent: the FSM holds its state and tx is stable indefinitely.
  - Reset mid-frame: next edge returns to IDLE with tx = 1, no tx_done_tick, and the partial frame is abandoned.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A parity register is loaded at accept with ^din ^ PARITY_ODD.
  - A PARITY state is inserted between DATA and STOP; tx = parity for OS ticks.
  - Frame length becomes (DBIT+2)*OS + SB_TICK ticks.
- Undefined:
  - DATA goes straight to STOP.
  - PARITY_ODD is ignored.
  - No parity register or state is synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - default constants OS = 16, DBIT = 8, SB_TICK = 16.
- The rx receiver reuses the package for matching frame constants.
- No sub-module: one FSM plus counters. A separate shifter module would add ports without removing any logic.

Test Plan:
1. Basic frame and loopback:
   - Stimulus: reset, s_tick every clk, tx_start pulse with din = 0xA5.
   - Response: tx = 0,1,0,1,0,0,1,0,1,1, each level 16 clks; tx_done_tick a single pulse 160 clks after accept; tx_busy high throughout.
   - Loopback into rx gives dout = 0xA5 with rx_done_tick.
2. Request while busy:
   - Stimulus: during the 0xA5 frame, tx_start with din = 0x3C at tick 50.
   - Response: ignored; the line carries 0xA5 only and stays high after done.
3. Back-to-back frames:
   - Stimulus: tx_start held high, din = 0x00 then 0xFF after the first done.
   - Response: second start bit begins 1 clk after tx_busy drops; both stop periods exactly 16 ticks; two done pulses.
4. Slow tick:
   - Stimulus: s_tick every 4th clk, din = 0x81.
   - Response: each bit 64 clks wide; done at 640 clks; tx constant between ticks.
5. Reset mid-frame:
   - Stimulus: reset asserted in DATA bit 3 for 1 clk.
   - Response: next edge tx = 1, tx_busy = 0, no done pulse.
   - A following frame with 0x5A is bit-exact.
6. Parity (UART_TX_PARITY_EN defined):
   - Stimulus: PARITY_ODD = 0 with din = 0x07; then PARITY_ODD = 1 with din = 0x03.
   - Response: parity bit = 1 for 0x07 (even) and 1 for 0x03 (odd); frame 176 ticks.
